draw_shape_ctrl: RTL and testbench
==================================

// Module: draw_shape_ctrl
// PURPOSE
//  Parametrised drawing-mode controller, successor to the 2-point draw-mode block.
//  Cycles through NUM_MODES drawing modes and collects up to MAX_PTS cursor points per shape.
//  Emits each completed shape on a valid/ready handshake to the shape rasteriser.
//  Sits between the button/cursor front end and the rasteriser.
// PARAMETERS
//  COORD_W    8  width of each x/y coordinate
//  NUM_MODES  6  number of modes (>=4): 0 freehand, 1 line, 2 rect, 3 spray, 4 triangle, 5 circle
//  MAX_PTS    3  point slots (>= largest pts_needed over all modes)
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  async active-low reset
//  btn_mode     in   1                  level, synchronised; rising edge advances mode
//  btn_point    in   1                  level; rising edge captures cursor as next point
//  btn_cancel   in   1                  level; rising edge discards collected points
//  x_pos        in   COORD_W            cursor x
//  y_pos        in   COORD_W            cursor y
//  mode         out  $clog2(NUM_MODES)  current mode
//  pt_count     out  $clog2(MAX_PTS+1)  points collected so far
//  pts_x        out  MAX_PTS*COORD_W    point i at [i*COORD_W +: COORD_W]
//  pts_y        out  MAX_PTS*COORD_W    same layout as pts_x
//  shape_valid  out  1                  completed shape offered
//  shape_mode   out  $clog2(NUM_MODES)  mode of offered shape
//  shape_ready  in   1                  rasteriser accepts
//  busy         out  1                  high in PENDING
// BEHAVIOUR
//  Reset: mode=0, pt_count=0, pts_x/pts_y=0, shape_valid=0, shape_mode=0, busy=0,
//   edge-detect history=0, state=COLLECT.
//  Edge detect: press = btn & ~btn_prev, registered per button; one action per press.
//  pts_needed(m): line 2, rect 2, triangle 3, circle 2 (centre, rim point), others 0.
//  State COLLECT:
//   - cancel press: pt_count<=0; mode unchanged. Highest priority.
//   - else mode press: mode<=mode+1, wrapping NUM_MODES-1 -> 0; pt_count<=0.
//     A point press in the same cycle is dropped.
//   - else point press with pts_needed(mode)>0: slot[pt_count]<=(x_pos,y_pos), pt_count+1.
//     If pt_count+1==pts_needed(mode): next cycle state=PENDING, shape_valid=1, shape_mode=mode.
//   - point press in a 0-point mode: ignored.
//  State PENDING:
//   - shape_valid held high. pts_x, pts_y, shape_mode, pt_count held stable until transfer.
//   - transfer on shape_valid && shape_ready (registered edge). Next cycle: shape_valid=0,
//     pt_count=0, state=COLLECT. Slot contents stay (not cleared).
//   - all button presses dropped, not queued; cancel cannot retract a committed shape.
//  shape_ready while not valid: no effect.
//  Latency: last point press edge -> shape_valid high 1 cycle later; no combinational in->out path.
//  Unused slots (index >= pts_needed) keep old values; the consumer ignores them.
//  Reset mid-PENDING: shape dropped, all outputs return to reset values asynchronously.
// STRUCTURE
//  draw_pkg: mode encodings (MODE_FREEHAND..MODE_CIRCLE), pts_needed() function,
//   state enum {COLLECT, PENDING}.
//  Sub-module btn_edge (registered rising-edge detector, async reset), instantiated 3x.
//  Top: one FSM plus a slot register file indexed by pt_count.
// TESTING
//  T1 reset, mode presses x7 -> mode 1,2,3,4,5,0,1; pt_count stays 0.
//  T2 mode=1, points (10,20),(30,40), ready=1 -> valid 1 cycle after 2nd press,
//     pts_x[7:0]=10, pts_x[15:8]=30, shape_mode=1; valid drops next cycle.
//  T3 mode=4, 3 points, ready=0 for 5 cycles -> valid and payload stable; point/mode presses
//     ignored, busy=1; ready=1 -> single transfer.
//  T4 mode=2, 1 point, then cancel -> pt_count 0; next 2 points form a fresh rect.
//  T5 same-cycle mode+point edges in mode 1 -> mode=2, pt_count=0;
//     cancel+point in same cycle -> pt_count=0.
//  T6 mode=3 point presses -> no change; rst_n low during PENDING -> all outputs reset at once.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the drawing-mode controller: mode encodings,
// per-mode point requirements and the controller state type.
package draw_pkg;

    localparam int MODE_FREEHAND = 0;
    localparam int MODE_LINE     = 1;
    localparam int MODE_RECT     = 2;
    localparam int MODE_SPRAY    = 3;
    localparam int MODE_TRIANGLE = 4;
    localparam int MODE_CIRCLE   = 5;

    typedef enum logic {
        COLLECT,
        PENDING
    } state_t;

    // Circle is defined by its centre plus one rim point, hence two points.
    function automatic int pts_needed(input int m);
        case (m)
            MODE_FREEHAND, MODE_SPRAY:       pts_needed = 0;
            MODE_LINE, MODE_RECT:            pts_needed = 2;
            MODE_CIRCLE:                     pts_needed = 2;
            MODE_TRIANGLE:                   pts_needed = 3;
            default:                         pts_needed = 0;
        endcase
    endfunction

endpackage

// File: rtl/draw_btn_edge.sv
// Registered rising-edge detector: one single-cycle press pulse per
// low-to-high transition of an already synchronised button level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic btn_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= 1'b0;
            press    <= 1'b0;
        end else begin
            btn_prev <= btn;
            press    <= btn & ~btn_prev;
        end
    end

endmodule

// File: rtl/draw_shape_ctrl.sv
// Drawing-mode controller: steps through drawing modes, collects cursor
// points per shape and offers each finished shape on a valid/ready handshake.
module draw_shape_ctrl
    import draw_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int NUM_MODES = 6,
    parameter int MAX_PTS   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           btn_mode,
    input  logic                           btn_point,
    input  logic                           btn_cancel,
    input  logic [COORD_W-1:0]             x_pos,
    input  logic [COORD_W-1:0]             y_pos,
    output logic [$clog2(NUM_MODES)-1:0]   mode,
    output logic [$clog2(MAX_PTS+1)-1:0]   pt_count,
    output logic [MAX_PTS*COORD_W-1:0]     pts_x,
    output logic [MAX_PTS*COORD_W-1:0]     pts_y,
    output logic                           shape_valid,
    output logic [$clog2(NUM_MODES)-1:0]   shape_mode,
    input  logic                           shape_ready,
    output logic                           busy
);

    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int CNT_W  = $clog2(MAX_PTS+1);

    logic mode_press;
    logic point_press;
    logic cancel_press;

    state_t                   state_q, state_d;
    logic [MODE_W-1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [MODE_W-1:0]        smode_q, smode_d;
    logic                     slot_we;
    logic [MAX_PTS*COORD_W-1:0] pts_x_q, pts_y_q;
    int                       need;

    btn_edge u_mode_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mode),
        .press (mode_press)
    );

    btn_edge u_point_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_point),
        .press (point_press)
    );

    btn_edge u_cancel_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_cancel),
        .press (cancel_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            mode_q  <= '0;
            cnt_q   <= '0;
            smode_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            smode_q <= smode_d;
        end
    end

    // Button priority in COLLECT is cancel, then mode, then point; PENDING ignores buttons.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        smode_d = smode_q;
        slot_we = 1'b0;
        need    = pts_needed(int'(mode_q));
        case (state_q)
            COLLECT: begin
                if (cancel_press) begin
                    cnt_d = '0;
                end else if (mode_press) begin
                    mode_d = (mode_q == MODE_W'(NUM_MODES-1)) ? '0 : mode_q + MODE_W'(1);
                    cnt_d  = '0;
                end else if (point_press && need > 0) begin
                    slot_we = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (int'(cnt_q) + 1 == need) begin
                        state_d = PENDING;
                        smode_d = mode_q;
                    end
                end
            end
            PENDING: begin
                if (shape_ready) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Slot storage is never cleared on transfer; only the slot at pt_count is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pts_x_q <= '0;
            pts_y_q <= '0;
        end else begin
            for (int i = 0; i < MAX_PTS; i++) begin
                if (slot_we && cnt_q == CNT_W'(i)) begin
                    pts_x_q[i*COORD_W +: COORD_W] <= x_pos;
                    pts_y_q[i*COORD_W +: COORD_W] <= y_pos;
                end
            end
        end
    end

    assign mode        = mode_q;
    assign pt_count    = cnt_q;
    assign pts_x       = pts_x_q;
    assign pts_y       = pts_y_q;
    assign shape_valid = (state_q == PENDING);
    assign shape_mode  = smode_q;
    assign busy        = (state_q == PENDING);

endmodule

// File: tb/tb_draw_shape_ctrl.sv
// Self-checking bench for draw_shape_ctrl: a behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_draw_shape_ctrl;

    localparam int COORD_W   = 8;
    localparam int NUM_MODES = 6;
    localparam int MAX_PTS   = 3;
    localparam int MODE_W    = $clog2(NUM_MODES);
    localparam int CNT_W     = $clog2(MAX_PTS+1);

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       btn_mode = 1'b0;
    logic                       btn_point = 1'b0;
    logic                       btn_cancel = 1'b0;
    logic [COORD_W-1:0]         x_pos = '0;
    logic [COORD_W-1:0]         y_pos = '0;
    logic [MODE_W-1:0]          mode;
    logic [CNT_W-1:0]           pt_count;
    logic [MAX_PTS*COORD_W-1:0] pts_x;
    logic [MAX_PTS*COORD_W-1:0] pts_y;
    logic                       shape_valid;
    logic [MODE_W-1:0]          shape_mode;
    logic                       shape_ready = 1'b0;
    logic                       busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    draw_shape_ctrl #(
        .COORD_W   (COORD_W),
        .NUM_MODES (NUM_MODES),
        .MAX_PTS   (MAX_PTS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_mode    (btn_mode),
        .btn_point   (btn_point),
        .btn_cancel  (btn_cancel),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .mode        (mode),
        .pt_count    (pt_count),
        .pts_x       (pts_x),
        .pts_y       (pts_y),
        .shape_valid (shape_valid),
        .shape_mode  (shape_mode),
        .shape_ready (shape_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input longint got, input longint exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: points needed per mode, indexed by mode number.
    int needed [NUM_MODES] = '{0, 2, 2, 0, 3, 2};
    int m_mode, m_cnt, m_smode;
    bit m_pend;
    int m_x [MAX_PTS];
    int m_y [MAX_PTS];
    logic [2:0] seen1, seen2;

    // A press seen at one edge acts at the following edge.
    always @(posedge clk or negedge rst_n) begin : model_step
        logic [2:0] evt;
        if (!rst_n) begin
            m_mode  <= 0;
            m_cnt   <= 0;
            m_smode <= 0;
            m_pend  <= 1'b0;
            seen1   <= '0;
            seen2   <= '0;
            for (int i = 0; i < MAX_PTS; i++) begin
                m_x[i] <= 0;
                m_y[i] <= 0;
            end
        end else begin
            evt = seen1 & ~seen2;
            seen2 <= seen1;
            seen1 <= {btn_cancel, btn_point, btn_mode};
            if (m_pend) begin
                if (shape_ready) begin
                    m_pend <= 1'b0;
                    m_cnt  <= 0;
                end
            end else if (evt[2]) begin
                m_cnt <= 0;
            end else if (evt[0]) begin
                m_mode <= (m_mode + 1) % NUM_MODES;
                m_cnt  <= 0;
            end else if (evt[1] && needed[m_mode] > 0) begin
                m_x[m_cnt] <= int'(x_pos);
                m_y[m_cnt] <= int'(y_pos);
                m_cnt      <= m_cnt + 1;
                if (m_cnt + 1 == needed[m_mode]) begin
                    m_pend  <= 1'b1;
                    m_smode <= m_mode;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [MAX_PTS*COORD_W-1:0] ex, ey;
        if (chk_en && rst_n) begin
            for (int i = 0; i < MAX_PTS; i++) begin
                ex[i*COORD_W +: COORD_W] = COORD_W'(m_x[i]);
                ey[i*COORD_W +: COORD_W] = COORD_W'(m_y[i]);
            end
            check_output("mdl_mode", longint'(mode), longint'(m_mode));
            check_output("mdl_pt_count", longint'(pt_count), longint'(m_cnt));
            check_output("mdl_pts_x", longint'(pts_x), longint'(ex));
            check_output("mdl_pts_y", longint'(pts_y), longint'(ey));
            check_output("mdl_valid", longint'(shape_valid), longint'(m_pend));
            check_output("mdl_busy", longint'(busy), longint'(m_pend));
            check_output("mdl_shape_mode", longint'(shape_mode), longint'(m_smode));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Raise the chosen buttons for one cycle, then wait until the press has acted.
    task automatic apply_stimulus(input logic m, input logic p, input logic c);
        btn_mode   = m;
        btn_point  = p;
        btn_cancel = c;
        step();
        btn_mode   = 1'b0;
        btn_point  = 1'b0;
        btn_cancel = 1'b0;
        step();
    endtask

    task automatic add_point(input int x, input int y);
        x_pos = COORD_W'(x);
        y_pos = COORD_W'(y);
        apply_stimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic mode_presses(input int n);
        repeat (n) apply_stimulus(1'b1, 1'b0, 1'b0);
    endtask

    int exp_modes [7] = '{1, 2, 3, 4, 5, 0, 1};

    initial begin
        rst_n = 1'b0;
        step(2);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check_output("rst_mode", longint'(mode), 0);
        check_output("rst_pt_count", longint'(pt_count), 0);
        check_output("rst_valid", longint'(shape_valid), 0);
        check_output("rst_busy", longint'(busy), 0);
        check_output("rst_pts_x", longint'(pts_x), 0);

        // T1: mode wraps after the last mode
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            check_output("t1_mode", longint'(mode), longint'(exp_modes[i]));
        end
        check_output("t1_pt_count", longint'(pt_count), 0);

        // T2: line with immediate acceptance
        add_point(10, 20);
        check_output("t2_cnt1", longint'(pt_count), 1);
        shape_ready = 1'b1;
        add_point(30, 40);
        check_output("t2_valid", longint'(shape_valid), 1);
        check_output("t2_x0", longint'(pts_x[7:0]), 10);
        check_output("t2_x1", longint'(pts_x[15:8]), 30);
        check_output("t2_y1", longint'(pts_y[15:8]), 40);
        check_output("t2_smode", longint'(shape_mode), 1);
        step();
        check_output("t2_valid_drop", longint'(shape_valid), 0);
        check_output("t2_cnt0", longint'(pt_count), 0);
        check_output("t2_x0_kept", longint'(pts_x[7:0]), 10);
        shape_ready = 1'b0;

        // T3: triangle held while the rasteriser stalls
        mode_presses(3);
        check_output("t3_mode", longint'(mode), 4);
        add_point(1, 2);
        add_point(3, 4);
        add_point(5, 6);
        check_output("t3_valid", longint'(shape_valid), 1);
        check_output("t3_busy", longint'(busy), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step();
        check_output("t3_hold_x", longint'(pts_x), longint'(24'h050301));
        check_output("t3_hold_y", longint'(pts_y), longint'(24'h060402));
        check_output("t3_hold_mode", longint'(mode), 4);
        check_output("t3_hold_cnt", longint'(pt_count), 3);
        check_output("t3_hold_valid", longint'(shape_valid), 1);
        check_output("t3_hold_smode", longint'(shape_mode), 4);
        shape_ready = 1'b1;
        step();
        shape_ready = 1'b0;
        check_output("t3_xfer_valid", longint'(shape_valid), 0);
        check_output("t3_xfer_cnt", longint'(pt_count), 0);
        step(2);
        check_output("t3_single", longint'(shape_valid), 0);

        // T4: cancel discards a half-built rect
        mode_presses(4);
        check_output("t4_mode", longint'(mode), 2);
        add_point(7, 8);
        check_output("t4_cnt1", longint'(pt_count), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("t4_cancel_cnt", longint'(pt_count), 0);
        check_output("t4_cancel_mode", longint'(mode), 2);
        add_point(9, 9);
        add_point(11, 12);
        check_output("t4_valid", longint'(shape_valid), 1);
        check_output("t4_x0", longint'(pts_x[7:0]), 9);
        check_output("t4_x1", longint'(pts_x[15:8]), 11);
        check_output("t4_smode", longint'(shape_mode), 2);
        shape_ready = 1'b1;
        step();
        shape_ready = 1'b0;

        // T5: simultaneous presses
        mode_presses(5);
        check_output("t5_mode1", longint'(mode), 1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("t5_mode2", longint'(mode), 2);
        check_output("t5_cnt0", longint'(pt_count), 0);
        add_point(20, 21);
        check_output("t5_cnt1", longint'(pt_count), 1);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_output("t5_cancel_pt", longint'(pt_count), 0);

        // T6: zero-point mode, then async reset while a shape is pending
        mode_presses(1);
        check_output("t6_mode3", longint'(mode), 3);
        add_point(50, 60);
        check_output("t6_spray_cnt", longint'(pt_count), 0);
        check_output("t6_spray_valid", longint'(shape_valid), 0);
        mode_presses(1);
        add_point(70, 71);
        add_point(72, 73);
        add_point(74, 75);
        check_output("t6_valid", longint'(shape_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("t6_rst_valid", longint'(shape_valid), 0);
        check_output("t6_rst_busy", longint'(busy), 0);
        check_output("t6_rst_mode", longint'(mode), 0);
        check_output("t6_rst_cnt", longint'(pt_count), 0);
        check_output("t6_rst_pts_x", longint'(pts_x), 0);
        check_output("t6_rst_pts_y", longint'(pts_y), 0);
        step();
        rst_n = 1'b1;
        step(2);
        check_output("t6_after_valid", longint'(shape_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
